// File: rtl/ctrl_pipe_pkg.sv
// Shared constants for the pipeline control path: opcode classes, control-bundle
// layouts, the all-zero bubble and the forwarding-select encodings.
// The forwarding encodings are only used when CTRL_PIPE_FWD_EN is defined.
package ctrl_pipe_pkg;

  // Opcode classes; the partial patterns are compared against the top opcode bits.
  localparam logic [2:0] OP_LOAD_HI   = 3'b100;
  localparam logic [2:0] OP_STORE_HI  = 3'b101;
  localparam logic [2:0] OP_ITYPE_HI  = 3'b001;
  localparam logic [4:0] OP_BRANCH_HI = 5'b00010;
  localparam logic [5:0] OP_RTYPE     = 6'b000000;
  localparam logic [5:0] OP_J         = 6'b000010;
  localparam logic [5:0] OP_JAL       = 6'b000011;
  localparam logic [5:0] OP_JR        = 6'b000111;
  localparam logic [5:0] OP_JALR      = 6'b010100;

  // ex_ctrl = {AluOp, ALUSrc, RegDst, Branch, Jump, PCSrc}
  localparam int unsigned EX_FIXED_W   = 5;
  localparam int unsigned EX_PCSRC     = 0;
  localparam int unsigned EX_JUMP      = 1;
  localparam int unsigned EX_BRANCH    = 2;
  localparam int unsigned EX_REGDST    = 3;
  localparam int unsigned EX_ALUSRC    = 4;
  localparam int unsigned EX_ALUOP_LSB = 5;

  // mem_ctrl = {MemRead, MemWrite}
  localparam int unsigned MEM_W     = 2;
  localparam int unsigned MEM_WRITE = 0;
  localparam int unsigned MEM_READ  = 1;

  // wb_ctrl = {RegWrite, MemtoReg, Jal}
  localparam int unsigned WB_W        = 3;
  localparam int unsigned WB_JAL      = 0;
  localparam int unsigned WB_MEMTOREG = 1;
  localparam int unsigned WB_REGWRITE = 2;

  // Wide enough for any stage field; sliced down to the field width at use.
  localparam int unsigned             BUBBLE_MAX_W = 64;
  localparam logic [BUBBLE_MAX_W-1:0] BUBBLE       = '0;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  function automatic int unsigned ex_w(input int unsigned aluop_w);
    return aluop_w + EX_FIXED_W;
  endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// ID-stage inputs and pipeline control outputs of ctrl_pipe.
// CTRL_PIPE_FWD_EN adds the fwd_a/fwd_b operand-select signals.
interface ctrl_pipe_if #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned ALUOP_W = 5
);
  logic [5:0]         opcode;
  logic [REG_AW-1:0]  id_rs;
  logic [REG_AW-1:0]  id_rt;
  logic [REG_AW-1:0]  id_rd;
  logic               flush;
  logic               mem_stall;
  logic               pc_write;
  logic               if_id_write;
  logic               if_id_flush;
  logic [ALUOP_W+4:0] ex_ctrl;
  logic [1:0]         mem_ctrl;
  logic [2:0]         wb_ctrl;
  logic [REG_AW-1:0]  wb_addr;
  logic               illegal;
`ifdef CTRL_PIPE_FWD_EN
  logic [1:0]         fwd_a;
  logic [1:0]         fwd_b;
`endif

  modport master (
    output opcode, id_rs, id_rt, id_rd, flush, mem_stall,
    input  pc_write, if_id_write, if_id_flush, ex_ctrl, mem_ctrl, wb_ctrl, wb_addr, illegal
`ifdef CTRL_PIPE_FWD_EN
    , input fwd_a, fwd_b
`endif
  );

  modport slave (
    input  opcode, id_rs, id_rt, id_rd, flush, mem_stall,
    output pc_write, if_id_write, if_id_flush, ex_ctrl, mem_ctrl, wb_ctrl, wb_addr, illegal
`ifdef CTRL_PIPE_FWD_EN
    , output fwd_a, fwd_b
`endif
  );

endinterface

// File: rtl/ctrl_pipe_decode.sv
// Combinational opcode decoder: control bundle, destination register,
// illegal flag and whether the instruction reads rt.
module ctrl_decode
  import ctrl_pipe_pkg::*;
#(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned ALUOP_W = 5
) (
  input  logic [5:0]                    opcode_i,
  input  logic [REG_AW-1:0]             rt_i,
  input  logic [REG_AW-1:0]             rd_i,
  output logic [ALUOP_W+EX_FIXED_W-1:0] ex_ctrl_o,
  output logic [MEM_W-1:0]              mem_ctrl_o,
  output logic [WB_W-1:0]               wb_ctrl_o,
  output logic [REG_AW-1:0]             dest_o,
  output logic                          illegal_o,
  output logic                          reads_rt_o
);

  logic is_load, is_store, is_i, is_b, is_r, is_j, is_jal, is_jr, is_jalr, legal, writes;
  logic [ALUOP_W-1:0] aluop;

  // Classify the opcode, then build each bundle; illegal opcodes decode to all zeros.
  always_comb begin
    is_load  = (opcode_i[5:3] == OP_LOAD_HI);
    is_store = (opcode_i[5:3] == OP_STORE_HI);
    is_i     = (opcode_i[5:3] == OP_ITYPE_HI);
    is_b     = (opcode_i[5:1] == OP_BRANCH_HI);
    is_r     = (opcode_i == OP_RTYPE);
    is_j     = (opcode_i == OP_J);
    is_jal   = (opcode_i == OP_JAL);
    is_jr    = (opcode_i == OP_JR);
    is_jalr  = (opcode_i == OP_JALR);
    legal    = is_load | is_store | is_i | is_b | is_r | is_j | is_jal | is_jr | is_jalr;

    aluop = '0;
    if (legal) begin
      aluop[1:0] = {is_r | is_i, is_b | is_i};
      aluop[4:2] = opcode_i[2:0];
    end

    ex_ctrl_o = '0;
    ex_ctrl_o[EX_ALUOP_LSB +: ALUOP_W] = aluop;
    ex_ctrl_o[EX_ALUSRC] = is_load | is_store | is_i;
    ex_ctrl_o[EX_REGDST] = is_r | is_jalr;
    ex_ctrl_o[EX_BRANCH] = is_b;
    ex_ctrl_o[EX_JUMP]   = is_j | is_jal | is_jr | is_jalr;
    // Register-target jumps take the PC from rs.
    ex_ctrl_o[EX_PCSRC]  = is_jr | is_jalr;

    mem_ctrl_o = '0;
    mem_ctrl_o[MEM_READ]  = is_load;
    mem_ctrl_o[MEM_WRITE] = is_store;

    dest_o = '0;
    if (is_r || is_jalr)      dest_o = rd_i;
    else if (is_load || is_i) dest_o = rt_i;
    else if (is_jal)          dest_o = REG_AW'(31);

    writes = is_load | is_i | is_r | is_jal | is_jalr;
    wb_ctrl_o = '0;
    wb_ctrl_o[WB_REGWRITE] = writes && (dest_o != '0);
    wb_ctrl_o[WB_MEMTOREG] = is_load;
    wb_ctrl_o[WB_JAL]      = is_jal | is_jalr;

    illegal_o  = ~legal;
    reads_rt_o = is_r | is_store | is_b;
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Registered pipeline control: decodes in ID, carries the bundle through
// ID/EX, EX/MEM and MEM/WB, and handles hazard stalls, flushes and memory stalls.
// CTRL_PIPE_FWD_EN: adds EX operand forwarding; only load-use still stalls.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned ALUOP_W    = 5,
  parameter bit          EXC_EN_DEF = 1'b1
) (
  input logic        clk,
  input logic        reset,
  ctrl_pipe_if.slave bus
);

  localparam int unsigned EXW = ex_w(ALUOP_W);

  if (ALUOP_W < 5) begin : g_aluop_w_check
    $error("ALUOP_W must be at least 5");
  end

  logic [EXW-1:0]    dec_ex;
  logic [MEM_W-1:0]  dec_mem;
  logic [WB_W-1:0]   dec_wb;
  logic [REG_AW-1:0] dec_dest;
  logic              dec_illegal, dec_reads_rt;

  ctrl_decode #(.REG_AW(REG_AW), .ALUOP_W(ALUOP_W)) u_decode (
    .opcode_i   (bus.opcode),
    .rt_i       (bus.id_rt),
    .rd_i       (bus.id_rd),
    .ex_ctrl_o  (dec_ex),
    .mem_ctrl_o (dec_mem),
    .wb_ctrl_o  (dec_wb),
    .dest_o     (dec_dest),
    .illegal_o  (dec_illegal),
    .reads_rt_o (dec_reads_rt)
  );

  logic [EXW-1:0]    idex_ex_q, idex_ex_d;
  logic [MEM_W-1:0]  idex_mem_q, idex_mem_d, exmem_mem_q, exmem_mem_d;
  logic [WB_W-1:0]   idex_wb_q, idex_wb_d, exmem_wb_q, exmem_wb_d, memwb_wb_q, memwb_wb_d;
  logic [REG_AW-1:0] idex_dest_q, idex_dest_d, exmem_dest_q, exmem_dest_d;
  logic [REG_AW-1:0] memwb_dest_q, memwb_dest_d;
  logic              idex_ill_q, idex_ill_d;
  logic              flush_pend_q, flush_pend_d;
  logic              exc_en_q;
`ifdef CTRL_PIPE_FWD_EN
  logic [REG_AW-1:0] idex_rs_q, idex_rs_d, idex_rt_q, idex_rt_d;
`endif

  logic ex_hit, mem_hit, load_use, hazard, flush_eff;
  logic pc_wr, if_id_wr, if_id_fl;

  // Hazard detection against the EX (and, without forwarding, MEM) destinations.
  always_comb begin
    ex_hit  = (idex_dest_q != '0) &&
              ((idex_dest_q == bus.id_rs) || (dec_reads_rt && (idex_dest_q == bus.id_rt)));
    mem_hit = (exmem_dest_q != '0) &&
              ((exmem_dest_q == bus.id_rs) || (dec_reads_rt && (exmem_dest_q == bus.id_rt)));
    load_use = idex_mem_q[MEM_READ] && ex_hit;
`ifdef CTRL_PIPE_FWD_EN
    hazard = load_use;
`else
    hazard = load_use || (idex_wb_q[WB_REGWRITE] && ex_hit) ||
             (exmem_wb_q[WB_REGWRITE] && mem_hit);
`endif
    // A flush seen while memory-stalled is applied on the first free cycle.
    flush_eff = bus.flush | flush_pend_q;
  end

  // Stage advance: mem_stall holds everything, then flush beats the hazard stall.
  always_comb begin
    idex_ex_d    = idex_ex_q;
    idex_mem_d   = idex_mem_q;
    idex_wb_d    = idex_wb_q;
    idex_dest_d  = idex_dest_q;
    idex_ill_d   = idex_ill_q;
    exmem_mem_d  = exmem_mem_q;
    exmem_wb_d   = exmem_wb_q;
    exmem_dest_d = exmem_dest_q;
    memwb_wb_d   = memwb_wb_q;
    memwb_dest_d = memwb_dest_q;
    flush_pend_d = flush_pend_q;
`ifdef CTRL_PIPE_FWD_EN
    idex_rs_d    = idex_rs_q;
    idex_rt_d    = idex_rt_q;
`endif
    pc_wr    = 1'b1;
    if_id_wr = 1'b1;
    if_id_fl = 1'b0;

    if (bus.mem_stall) begin
      pc_wr        = 1'b0;
      if_id_wr     = 1'b0;
      flush_pend_d = flush_pend_q | bus.flush;
    end else begin
      flush_pend_d = 1'b0;
      exmem_mem_d  = idex_mem_q;
      exmem_wb_d   = idex_wb_q;
      exmem_dest_d = idex_dest_q;
      memwb_wb_d   = exmem_wb_q;
      memwb_dest_d = exmem_dest_q;
      if (flush_eff || hazard) begin
        idex_ex_d   = BUBBLE[EXW-1:0];
        idex_mem_d  = BUBBLE[MEM_W-1:0];
        idex_wb_d   = BUBBLE[WB_W-1:0];
        idex_dest_d = BUBBLE[REG_AW-1:0];
        idex_ill_d  = 1'b0;
`ifdef CTRL_PIPE_FWD_EN
        idex_rs_d   = BUBBLE[REG_AW-1:0];
        idex_rt_d   = BUBBLE[REG_AW-1:0];
`endif
        if (flush_eff) begin
          if_id_fl = 1'b1;
        end else begin
          pc_wr    = 1'b0;
          if_id_wr = 1'b0;
        end
      end else begin
        idex_ex_d   = dec_ex;
        idex_mem_d  = dec_mem;
        idex_wb_d   = dec_wb;
        idex_dest_d = dec_dest;
        idex_ill_d  = dec_illegal;
`ifdef CTRL_PIPE_FWD_EN
        idex_rs_d   = bus.id_rs;
        idex_rt_d   = bus.id_rt;
`endif
      end
    end

    if (reset) begin
      pc_wr    = 1'b1;
      if_id_wr = 1'b1;
      if_id_fl = 1'b0;
    end
  end

  // Stage registers; reset loads a bubble everywhere and drops any held state.
  always_ff @(posedge clk) begin
    if (reset) begin
      idex_ex_q    <= '0;
      idex_mem_q   <= '0;
      idex_wb_q    <= '0;
      idex_dest_q  <= '0;
      idex_ill_q   <= 1'b0;
      exmem_mem_q  <= '0;
      exmem_wb_q   <= '0;
      exmem_dest_q <= '0;
      memwb_wb_q   <= '0;
      memwb_dest_q <= '0;
      flush_pend_q <= 1'b0;
      exc_en_q     <= EXC_EN_DEF;
`ifdef CTRL_PIPE_FWD_EN
      idex_rs_q    <= '0;
      idex_rt_q    <= '0;
`endif
    end else begin
      idex_ex_q    <= idex_ex_d;
      idex_mem_q   <= idex_mem_d;
      idex_wb_q    <= idex_wb_d;
      idex_dest_q  <= idex_dest_d;
      idex_ill_q   <= idex_ill_d;
      exmem_mem_q  <= exmem_mem_d;
      exmem_wb_q   <= exmem_wb_d;
      exmem_dest_q <= exmem_dest_d;
      memwb_wb_q   <= memwb_wb_d;
      memwb_dest_q <= memwb_dest_d;
      flush_pend_q <= flush_pend_d;
`ifdef CTRL_PIPE_FWD_EN
      idex_rs_q    <= idex_rs_d;
      idex_rt_q    <= idex_rt_d;
`endif
    end
  end

`ifdef CTRL_PIPE_FWD_EN
  logic [1:0] fwd_a, fwd_b;

  // Operand source select; the younger producer in EX/MEM wins, $0 never forwards.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (exmem_wb_q[WB_REGWRITE] && (exmem_dest_q != '0) && (exmem_dest_q == idex_rs_q))
      fwd_a = FWD_EXMEM;
    else if (memwb_wb_q[WB_REGWRITE] && (memwb_dest_q != '0) && (memwb_dest_q == idex_rs_q))
      fwd_a = FWD_MEMWB;
    if (exmem_wb_q[WB_REGWRITE] && (exmem_dest_q != '0) && (exmem_dest_q == idex_rt_q))
      fwd_b = FWD_EXMEM;
    else if (memwb_wb_q[WB_REGWRITE] && (memwb_dest_q != '0) && (memwb_dest_q == idex_rt_q))
      fwd_b = FWD_MEMWB;
  end

  assign bus.fwd_a = fwd_a;
  assign bus.fwd_b = fwd_b;
`endif

  assign bus.pc_write    = pc_wr;
  assign bus.if_id_write = if_id_wr;
  assign bus.if_id_flush = if_id_fl;
  assign bus.ex_ctrl     = idex_ex_q;
  assign bus.mem_ctrl    = exmem_mem_q;
  assign bus.wb_ctrl     = memwb_wb_q;
  assign bus.wb_addr     = memwb_dest_q;
  assign bus.illegal     = idex_ill_q & exc_en_q & ~bus.mem_stall & ~reset;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe; expected bundles are hand-encoded constants.
module tb_ctrl_pipe;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BAD = 6'b111111;

  // ex_ctrl = {AluOp[4:0], ALUSrc, RegDst, Branch, Jump, PCSrc}
  localparam logic [9:0] EX_LW  = 10'b01100_10000;
  localparam logic [9:0] EX_ADD = 10'b00010_01000;
  localparam logic [9:0] EX_BEQ = 10'b10001_00100;
  localparam logic [9:0] EX_JAL = 10'b01100_00010;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  ctrl_pipe_if #(.REG_AW(5), .ALUOP_W(5)) bus ();

  ctrl_pipe #(.REG_AW(5), .ALUOP_W(5), .EXC_EN_DEF(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic id(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                    input logic [4:0] rd);
    bus.opcode = op;
    bus.id_rs  = rs;
    bus.id_rt  = rt;
    bus.id_rd  = rd;
    #1;
  endtask

  task automatic nops(input int n);
    id(OP_R, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    reset         = 1'b1;
    bus.flush     = 1'b0;
    bus.mem_stall = 1'b0;
    id(OP_R, 5'd0, 5'd0, 5'd0);
    chk("rst_pc_write", 32'(bus.pc_write), 32'd1);
    chk("rst_if_id_write", 32'(bus.if_id_write), 32'd1);
    chk("rst_if_id_flush", 32'(bus.if_id_flush), 32'd0);
    chk("rst_illegal", 32'(bus.illegal), 32'd0);
    cyc();
    cyc();
    reset = 1'b0;
    id(OP_R, 5'd0, 5'd0, 5'd0);
    chk("rst_ex", 32'(bus.ex_ctrl), 32'd0);
    chk("rst_mem", 32'(bus.mem_ctrl), 32'd0);
    chk("rst_wb", 32'(bus.wb_ctrl), 32'd0);
    chk("rst_wb_addr", 32'(bus.wb_addr), 32'd0);

    // lw $8 latency through the three stage registers
    id(OP_LW, 5'd1, 5'd8, 5'd0);
    chk("lw_no_stall", 32'(bus.pc_write), 32'd1);
    cyc();
    id(OP_R, 5'd0, 5'd0, 5'd0);
    chk("lw_ex", 32'(bus.ex_ctrl), 32'(EX_LW));
    cyc();
    chk("lw_mem", 32'(bus.mem_ctrl), 32'b10);
    cyc();
    chk("lw_wb", 32'(bus.wb_ctrl), 32'b110);
    chk("lw_wb_addr", 32'(bus.wb_addr), 32'd8);
    nops(3);

    // lw $8 ; add $10,$8,$9 -> load-use stall
    id(OP_LW, 5'd1, 5'd8, 5'd0);
    cyc();
    id(OP_R, 5'd8, 5'd9, 5'd10);
    chk("lu_pc_write", 32'(bus.pc_write), 32'd0);
    chk("lu_if_id_write", 32'(bus.if_id_write), 32'd0);
    chk("lu_ex_lw", 32'(bus.ex_ctrl), 32'(EX_LW));
    cyc();
    chk("lu_bubble", 32'(bus.ex_ctrl), 32'd0);
`ifndef CTRL_PIPE_FWD_EN
    // without forwarding the add also waits while the lw sits in MEM
    chk("raw_pc_write", 32'(bus.pc_write), 32'd0);
    cyc();
    chk("raw_bubble", 32'(bus.ex_ctrl), 32'd0);
`endif
    chk("lu_release_pc", 32'(bus.pc_write), 32'd1);
    chk("lu_release_ifid", 32'(bus.if_id_write), 32'd1);
    cyc();
    id(OP_R, 5'd0, 5'd0, 5'd0);
    chk("add_ex", 32'(bus.ex_ctrl), 32'(EX_ADD));
`ifdef CTRL_PIPE_FWD_EN
    chk("add_fwd_a_memwb", 32'(bus.fwd_a), 32'b01);
`endif
    cyc();
    cyc();
    chk("add_wb", 32'(bus.wb_ctrl), 32'b100);
    chk("add_wb_addr", 32'(bus.wb_addr), 32'd10);
    nops(3);

    // flush beats load-use stall; EX lw proceeds
    id(OP_LW, 5'd1, 5'd8, 5'd0);
    cyc();
    bus.flush = 1'b1;
    id(OP_R, 5'd8, 5'd9, 5'd10);
    chk("fl_if_id_flush", 32'(bus.if_id_flush), 32'd1);
    chk("fl_pc_write", 32'(bus.pc_write), 32'd1);
    chk("fl_if_id_write", 32'(bus.if_id_write), 32'd1);
    cyc();
    bus.flush = 1'b0;
    id(OP_R, 5'd0, 5'd0, 5'd0);
    chk("fl_bubble", 32'(bus.ex_ctrl), 32'd0);
    chk("fl_lw_mem", 32'(bus.mem_ctrl), 32'b10);
    nops(3);

    // mem_stall for 3 cycles with beq in EX, lw in MEM, flush held throughout
    id(OP_LW, 5'd1, 5'd8, 5'd0);
    cyc();
    id(OP_BEQ, 5'd1, 5'd2, 5'd0);
    cyc();
    bus.mem_stall = 1'b1;
    bus.flush     = 1'b1;
    id(OP_R, 5'd4, 5'd5, 5'd6);
    chk("ms_pc_write", 32'(bus.pc_write), 32'd0);
    chk("ms_if_id_write", 32'(bus.if_id_write), 32'd0);
    chk("ms_if_id_flush", 32'(bus.if_id_flush), 32'd0);
    chk("ms_ex_beq", 32'(bus.ex_ctrl), 32'(EX_BEQ));
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("ms_hold_ex", 32'(bus.ex_ctrl), 32'(EX_BEQ));
      chk("ms_hold_mem", 32'(bus.mem_ctrl), 32'b10);
      chk("ms_hold_wb", 32'(bus.wb_ctrl), 32'd0);
      chk("ms_hold_pc", 32'(bus.pc_write), 32'd0);
    end
    cyc();
    bus.mem_stall = 1'b0;
    #1;
    chk("ms_free_flush", 32'(bus.if_id_flush), 32'd1);
    chk("ms_free_pc", 32'(bus.pc_write), 32'd1);
    chk("ms_free_ex", 32'(bus.ex_ctrl), 32'(EX_BEQ));
    chk("ms_free_wb", 32'(bus.wb_ctrl), 32'd0);
    cyc();
    bus.flush = 1'b0;
    id(OP_R, 5'd0, 5'd0, 5'd0);
    chk("ms_after_ex", 32'(bus.ex_ctrl), 32'd0);
    chk("ms_after_mem", 32'(bus.mem_ctrl), 32'd0);
    chk("ms_after_wb", 32'(bus.wb_ctrl), 32'b110);
    chk("ms_after_wb_addr", 32'(bus.wb_addr), 32'd8);
    nops(3);

    // illegal opcode: one-cycle pulse with zero control
    id(OP_BAD, 5'd0, 5'd0, 5'd0);
    chk("ill_pre", 32'(bus.illegal), 32'd0);
    cyc();
    id(OP_R, 5'd0, 5'd0, 5'd0);
    chk("ill_pulse", 32'(bus.illegal), 32'd1);
    chk("ill_ex", 32'(bus.ex_ctrl), 32'd0);
    cyc();
    chk("ill_drop", 32'(bus.illegal), 32'd0);
    chk("ill_mem", 32'(bus.mem_ctrl), 32'd0);
    cyc();
    chk("ill_wb", 32'(bus.wb_ctrl), 32'd0);

    // jal writes $31
    id(OP_JAL, 5'd0, 5'd0, 5'd0);
    cyc();
    id(OP_R, 5'd0, 5'd0, 5'd0);
    chk("jal_ex", 32'(bus.ex_ctrl), 32'(EX_JAL));
    cyc();
    chk("jal_mem", 32'(bus.mem_ctrl), 32'd0);
    cyc();
    chk("jal_wb", 32'(bus.wb_ctrl), 32'b101);
    chk("jal_wb_addr", 32'(bus.wb_addr), 32'd31);
    nops(2);

    // reset during a memory stall discards the held pipeline
    id(OP_LW, 5'd1, 5'd8, 5'd0);
    cyc();
    bus.mem_stall = 1'b1;
    reset         = 1'b1;
    id(OP_R, 5'd8, 5'd9, 5'd10);
    chk("rs_pc_write", 32'(bus.pc_write), 32'd1);
    cyc();
    reset         = 1'b0;
    bus.mem_stall = 1'b0;
    id(OP_R, 5'd0, 5'd0, 5'd0);
    chk("rs_ex", 32'(bus.ex_ctrl), 32'd0);
    chk("rs_mem", 32'(bus.mem_ctrl), 32'd0);
    chk("rs_wb", 32'(bus.wb_ctrl), 32'd0);
    chk("rs_pc_after", 32'(bus.pc_write), 32'd1);

`ifdef CTRL_PIPE_FWD_EN
    nops(3);
    id(OP_R, 5'd1, 5'd2, 5'd3);
    cyc();
    id(OP_R, 5'd3, 5'd4, 5'd5);
    cyc();
    id(OP_R, 5'd0, 5'd0, 5'd0);
    chk("fwd_a_exmem", 32'(bus.fwd_a), 32'b10);
    chk("fwd_b_rf", 32'(bus.fwd_b), 32'b00);
    nops(3);
    id(OP_R, 5'd1, 5'd2, 5'd3);
    cyc();
    id(OP_R, 5'd0, 5'd0, 5'd0);
    cyc();
    id(OP_R, 5'd3, 5'd4, 5'd5);
    cyc();
    id(OP_R, 5'd0, 5'd0, 5'd0);
    chk("fwd_a_memwb", 32'(bus.fwd_a), 32'b01);
    nops(3);
    id(OP_R, 5'd1, 5'd2, 5'd0);
    cyc();
    id(OP_R, 5'd0, 5'd4, 5'd5);
    cyc();
    id(OP_R, 5'd0, 5'd0, 5'd0);
    chk("fwd_a_r0", 32'(bus.fwd_a), 32'b00);
    nops(3);
    id(OP_R, 5'd1, 5'd2, 5'd7);
    cyc();
    id(OP_R, 5'd1, 5'd2, 5'd7);
    cyc();
    id(OP_R, 5'd4, 5'd7, 5'd9);
    cyc();
    id(OP_R, 5'd0, 5'd0, 5'd0);
    chk("fwd_b_tie", 32'(bus.fwd_b), 32'b10);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Registered, parametrised successor to the combinational opcode decoder.
- Decodes the ID-stage opcode into a control bundle and carries it through ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and inserts bubbles; applies branch/jump flushes and global memory stalls.
- Drives the PC and IF/ID write enables for the 5-stage MIPS-style pipeline.

Parameters:
- REG_AW, 5, register address width.
- ALUOP_W, 5, ALU operation code width; must be ≥5. Low 2 bits are class bits; bits [4:2] are opcode[2:0]; upper bits are zero.
- EXC_EN_DEF, 1, reset value of the illegal-opcode trap enable.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clears all pipeline control registers
- opcode  in  6  ID-stage instruction opcode
- id_rs  in  REG_AW  ID-stage source register 1
- id_rt  in  REG_AW  ID-stage source register 2
- id_rd  in  REG_AW  ID-stage destination field
- flush  in  1  branch/jump taken, resolved in EX
- mem_stall  in  1  data memory not ready; freeze all stages
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID register enable
- if_id_flush  out  1  clear IF/ID register
- ex_ctrl  out  ALUOP_W+5  {AluOp, ALUSrc, RegDst, Branch, Jump, PCSrc}
- mem_ctrl  out  2  {MemRead, MemWrite}
- wb_ctrl  out  3  {RegWrite, MemtoReg, Jal}
- wb_addr  out  REG_AW  write-back destination register
- illegal  out  1  one-cycle pulse: an undecodable opcode reached EX

Behaviour:
- Opcode classes (one-hot, no overlap):
  - load = 100xxx; store = 101xxx; i_type = 001xxx
  - branch = 00010x; r_type = 000000
  - j = 000010; jal = 000011; jr = 000111; jalr = 010100
  - Anything else is illegal.
- Decode rules are the same as the existing decoder: RegSrc folds into Jal/PCSrc, and AluOp[1:0] = {r|i, b|i}.
- Destination register:
  - rd for r_type/jalr; rt for load/i_type; 31 for jal.
  - RegWrite=0 when the destination is 0.
- Latency: ID decode appears on ex_ctrl 1 cycle later, on mem_ctrl 2 cycles later, on wb_ctrl/wb_addr 3 cycles later.
- Load-use stall (without forwarding):
  - Condition: EX-stage MemRead=1, its dest ≠ 0, and dest == id_rs, or dest == id_rt when the ID instruction reads rt (r_type, store, branch).
  - Response: pc_write=0, if_id_write=0, and an all-zero bubble enters ID/EX.
  - Lasts exactly 1 cycle per hazard.
- flush:
  - ID/EX loads a bubble and if_id_flush=1 in the same cycle.
  - The EX instruction (the branch itself) proceeds.
  - flush has priority over a load-use stall; pc_write=1 during flush.
- mem_stall:
  - All four stage registers hold; pc_write=0, if_id_write=0, if_id_flush=0.
  - Overrides flush and the hazard stall; a held flush is re-applied when mem_stall drops.
- Bubble contents: all control bits 0, wb_addr=0, illegal=0.
- Reset:
  - All stage registers clear to bubble; pc_write=1, if_id_write=1, if_id_flush=0, illegal=0.
  - Reset mid-stall discards the held state.
- illegal:
  - Asserts when an illegal entry is in EX and not stalled.
  - That entry carries zero control bits, so it never writes a register or memory.

Optional Feature:
- Macro: CTRL_PIPE_FWD_EN.
- When defined:
  - Adds outputs fwd_a and fwd_b (2 bits each, for EX operands rs/rt): 10 = from EX/MEM, 01 = from MEM/WB, 00 = from the register file.
  - EX/MEM wins a tie; destination 0 is never forwarded.
  - The load-use stall is kept.
  - Adds registered id_ex_rs/rt tracking.
- When undefined:
  - No fwd ports.
  - The stall also covers any RAW against EX or MEM destinations with RegWrite=1, lasting 1–2 cycles until the producer reaches WB.
  - Assumes a write-first register file.

Decomposition:
- Package ctrl_pipe_pkg holds:
  - opcode class constants;
  - the bundle field widths and bit positions for ex_ctrl, mem_ctrl and wb_ctrl;
  - the BUBBLE constant;
  - the FWD_* encodings.
- One sub-module, ctrl_decode: purely combinational opcode → bundle, plus illegal and the reads-rt flag.
- Stage registers and hazard logic stay in ctrl_pipe.

Test Plan:
- Reset held 2 cycles, then `lw` (opcode 100011, rt=8) → ex_ctrl shows ALUSrc=1 and AluOp[1:0]=00 next cycle; mem_ctrl=10 at +2; wb_ctrl={1,1,0} with wb_addr=8 at +3.
- `lw` $8 followed by `add` with rs=8 → exactly one cycle with pc_write=0 and if_id_write=0, and a zero bubble on ex_ctrl; the add follows.
- `beq` in EX with flush=1 while ID holds a `lw`-dependent instruction → if_id_flush=1, bubble into EX, pc_write=1 (flush beats stall).
- mem_stall=1 for 3 cycles mid-stream → ex/mem/wb outputs frozen, pc_write=0; a flush asserted during the stall is honoured on the first free cycle.
- Opcode 111111 → illegal pulses 1 cycle later and all control bits are 0. `jal` → wb_addr=31 and Jal=1 at +3.
- With CTRL_PIPE_FWD_EN: `add $3` followed by `sub` with rs=3 → fwd_a=10 at the sub's EX. With one intervening instruction → fwd_a=01. With dest $0 → fwd_a=00.
